// File: rtl/clk_delay_pkg.sv
// Shared constants and types for the clock-delay divider and its feedback meter.
// CNT_W  : period counter width (matches the divider counter).
// SHIFT  : speed code = period >> SHIFT.
// CODE_W : speed code width; CNT_W = SHIFT + CODE_W.
package clk_delay_pkg;

    localparam int unsigned CNT_W  = 28;
    localparam int unsigned SHIFT  = 20;
    localparam int unsigned CODE_W = 8;

    typedef enum logic {
        IDLE,
        MEASURE
    } meter_state_t;

endpackage

// File: rtl/rise_detect.sv
// One-register rising-edge detector for a CLK-synchronous input.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset (clears the history register)
//   i_in    : input level
//   o_edge  : high in the cycle i_in is high and was low the cycle before
// Because reset clears the history, an input held high through reset release
// is reported as an edge.
module rise_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_in,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_in;
        end
    end

    assign o_edge = i_in & ~r_prev;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the CLK-cycle interval between rising edges of a tick stream and
// converts it back into the divider speed code, with a Valid/Ack handshake.
// Ports:
//   i_clk      : clock, rising edge
//   i_reset    : synchronous active-high reset
//   i_tick_in  : tick stream, synchronous to i_clk; rising edge counts
//   i_ack      : consumer acknowledge; clears o_valid and o_overrun
//   o_period   : last measured interval in CLK cycles
//   o_code     : o_period[CNT_W-1:SHIFT]
//   o_valid    : a new result is held until acknowledged
//   o_overrun  : sticky; a result was overwritten while o_valid was high
//   o_stalled  : no edge seen for 2^CNT_W-1 cycles; cleared by the next edge
module tick_period_meter #(
    parameter int unsigned CNT_W  = clk_delay_pkg::CNT_W,
    parameter int unsigned SHIFT  = clk_delay_pkg::SHIFT,
    parameter int unsigned CODE_W = clk_delay_pkg::CODE_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_tick_in,
    input  logic              i_ack,
    output logic [CNT_W-1:0]  o_period,
    output logic [CODE_W-1:0] o_code,
    output logic              o_valid,
    output logic              o_overrun,
    output logic              o_stalled
);

    import clk_delay_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             w_edge;
    meter_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CODE_W-1:0] r_code;
    logic             r_valid;
    logic             r_overrun;
    logic             r_stalled;

    rise_detect u_rise_detect (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_in    (i_tick_in),
        .o_edge  (w_edge)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            // Handshake first; a result loaded below in the same cycle wins.
            if (i_ack && r_valid) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        r_state   <= MEASURE;
                        r_cnt     <= CNT_ONE;
                        r_stalled <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (w_edge) begin
                        r_period  <= r_cnt;
                        r_code    <= r_cnt[CNT_W-1:SHIFT];
                        r_valid   <= 1'b1;
                        r_cnt     <= CNT_ONE;
                        r_stalled <= 1'b0;
                        // Overwriting an unacknowledged result; an Ack in
                        // this same cycle counts as consuming it.
                        if (r_valid && !i_ack) begin
                            r_overrun <= 1'b1;
                        end
                    end else if (r_cnt == CNT_MAX) begin
                        // Timeout: drop the interval, keep the last result.
                        r_state   <= IDLE;
                        r_cnt     <= '0;
                        r_stalled <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign o_period  = r_period;
    assign o_code    = r_code;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
    assign o_stalled = r_stalled;

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter, scaled to CNT_W=12, SHIFT=4, CODE_W=8
// so that a "code 1" interval is 2^4+2 = 18 cycles and the stall timeout is
// 4095 cycles. Inputs change and outputs are sampled 1 time unit after each
// rising clock edge.
module tb_tick_period_meter;

    localparam int unsigned CW = 12;
    localparam int unsigned SH = 4;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          reset;
    logic          tick;
    logic          ack;
    logic [CW-1:0] period;
    logic [DW-1:0] code;
    logic          valid;
    logic          overrun;
    logic          stalled;

    int n_checks = 0;
    int n_fail   = 0;

    tick_period_meter #(
        .CNT_W  (CW),
        .SHIFT  (SH),
        .CODE_W (DW)
    ) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_tick_in (tick),
        .i_ack     (ack),
        .o_period  (period),
        .o_code    (code),
        .o_valid   (valid),
        .o_overrun (overrun),
        .o_stalled (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One cycle with tick high (a rising edge if tick was low), then tick low.
    task automatic send_edge();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick  = 1'b0;
        ack   = 1'b0;
        step(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick  = 1'b0;
        ack   = 1'b0;
        step(2);
        reset = 1'b0;
        n_checks++;
        if (period !== 12'd0) begin
            n_fail++; $display("FAIL reset period: got %0d want 0", period);
        end
        n_checks++;
        if (code !== 8'd0) begin
            n_fail++; $display("FAIL reset code: got %0d want 0", code);
        end
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL reset valid: got %b want 0", valid);
        end
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++; $display("FAIL reset overrun: got %b want 0", overrun);
        end
        n_checks++;
        if (stalled !== 1'b0) begin
            n_fail++; $display("FAIL reset stalled: got %b want 0", stalled);
        end
    endtask

    task automatic test_min_period();
        do_reset();
        send_edge();
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL min_period first_edge valid: got %b want 0", valid);
        end
        step(1);
        send_edge();
        n_checks++;
        if (period !== 12'd2) begin
            n_fail++; $display("FAIL min_period period: got %0d want 2", period);
        end
        n_checks++;
        if (code !== 8'd0) begin
            n_fail++; $display("FAIL min_period code: got %0d want 0", code);
        end
        n_checks++;
        if (valid !== 1'b1) begin
            n_fail++; $display("FAIL min_period valid: got %b want 1", valid);
        end
        // Back-to-back: another edge two cycles later overwrites.
        step(1);
        send_edge();
        n_checks++;
        if (overrun !== 1'b1 || period !== 12'd2) begin
            n_fail++;
            $display("FAIL back_to_back: got overrun=%b period=%0d want 1/2", overrun, period);
        end
    endtask

    task automatic test_code_one();
        do_reset();
        send_edge();
        step(17);
        send_edge();
        n_checks++;
        if (period !== 12'd18 || code !== 8'd1 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL code_one: got period=%0d code=%0d valid=%b want 18/1/1",
                     period, code, valid);
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || period !== 12'd18) begin
            n_fail++;
            $display("FAIL code_one ack: got valid=%b period=%0d want 0/18", valid, period);
        end
        // Interval 82 = 5*16 + 2 -> code 5 (ack cycle counts toward it).
        step(80);
        send_edge();
        n_checks++;
        if (period !== 12'd82 || code !== 8'd5 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL code_five: got period=%0d code=%0d overrun=%b want 82/5/0",
                     period, code, overrun);
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        // Interval 31 truncates to code 1.
        step(29);
        send_edge();
        n_checks++;
        if (period !== 12'd31 || code !== 8'd1) begin
            n_fail++;
            $display("FAIL truncate: got period=%0d code=%0d want 31/1", period, code);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_edge();
        step(4);
        send_edge();
        n_checks++;
        if (period !== 12'd5 || valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun first: got period=%0d valid=%b overrun=%b want 5/1/0",
                     period, valid, overrun);
        end
        step(6);
        send_edge();
        n_checks++;
        if (period !== 12'd7 || valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun second: got period=%0d valid=%b overrun=%b want 7/1/1",
                     period, valid, overrun);
        end
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        n_checks++;
        if (valid !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun ack: got valid=%b overrun=%b want 0/0", valid, overrun);
        end
    endtask

    task automatic test_ack_same_cycle();
        do_reset();
        send_edge();
        step(2);
        send_edge();
        step(3);
        send_edge();
        n_checks++;
        if (period !== 12'd4 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_same setup: got period=%0d overrun=%b want 4/1", period, overrun);
        end
        step(4);
        ack = 1'b1;
        send_edge();
        ack = 1'b0;
        n_checks++;
        if (period !== 12'd5 || valid !== 1'b1 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_same: got period=%0d valid=%b overrun=%b want 5/1/0",
                     period, valid, overrun);
        end
    endtask

    task automatic test_stall();
        do_reset();
        send_edge();
        step(9);
        send_edge();
        step(4094);
        n_checks++;
        if (stalled !== 1'b0) begin
            n_fail++; $display("FAIL stall early: got %b want 0", stalled);
        end
        step(1);
        n_checks++;
        if (stalled !== 1'b1 || valid !== 1'b1 || period !== 12'd10) begin
            n_fail++;
            $display("FAIL stall: got stalled=%b valid=%b period=%0d want 1/1/10",
                     stalled, valid, period);
        end
        // First edge after a stall restarts measurement only.
        send_edge();
        n_checks++;
        if (stalled !== 1'b0 || period !== 12'd10 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL stall restart: got stalled=%b period=%0d overrun=%b want 0/10/0",
                     stalled, period, overrun);
        end
        step(5);
        send_edge();
        n_checks++;
        if (period !== 12'd6 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL stall result: got period=%0d overrun=%b want 6/1", period, overrun);
        end
    endtask

    task automatic test_stall_boundary();
        // Interval of exactly 2^CNT_W-1 is still a valid result.
        do_reset();
        send_edge();
        step(4094);
        send_edge();
        n_checks++;
        if (period !== 12'd4095 || code !== 8'd255 || valid !== 1'b1 || stalled !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_boundary: got period=%0d code=%0d valid=%b stalled=%b want 4095/255/1/0",
                     period, code, valid, stalled);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_edge();
        step(5);
        send_edge();
        step(1);
        send_edge();
        step(3);
        n_checks++;
        if (valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid setup: got valid=%b overrun=%b want 1/1", valid, overrun);
        end
        reset = 1'b1;
        tick  = 1'b1;
        step(1);
        n_checks++;
        if (period !== 12'd0 || code !== 8'd0 || valid !== 1'b0 || overrun !== 1'b0 ||
            stalled !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid clear: got period=%0d code=%0d valid=%b overrun=%b stalled=%b",
                     period, code, valid, overrun, stalled);
        end
        // Tick still high at release counts as the first edge.
        reset = 1'b0;
        step(1);
        tick = 1'b0;
        n_checks++;
        if (valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid release valid: got %b want 0", valid);
        end
        step(3);
        send_edge();
        n_checks++;
        if (period !== 12'd4 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid result: got period=%0d valid=%b want 4/1", period, valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        ack   = 1'b0;
        test_reset();
        test_min_period();
        test_code_one();
        test_overrun();
        test_ack_same_cycle();
        test_stall();
        test_stall_boundary();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the interval, in CLK cycles, between consecutive rising edges of a synchronous tick stream and converts it back into the 8-bit speed code that the clock-delay divider uses to generate such a stream. The result is a raw period plus the code, delivered through a Valid/Ack handshake. It sits on the feedback side of the rocking-speed path, so a measured rocking rate can be compared against the commanded one. It also reports a stalled input and overwritten results.

## Interface
- CNT_W, 28: period counter width; matches the divider counter.
- SHIFT, 20: code = Period >> SHIFT.
- CODE_W, 8: speed code width; CNT_W = SHIFT + CODE_W.
- CLK  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- TickIn  in  1  tick stream, synchronous to CLK; pulse or level, rising edge counts.
- Ack  in  1  consumer acknowledge; clears Valid and Overrun.
- Period  out  CNT_W  last measured interval in CLK cycles.
- Code  out  CODE_W  Period[CNT_W-1:SHIFT].
- Valid  out  1  new result held; stays high until Ack.
- Overrun  out  1  sticky; a result was overwritten while Valid was high.
- Stalled  out  1  no edge within 2^CNT_W-1 cycles; level.

## Operation
- Edge detect: `tick_q <= TickIn`; `edge = TickIn & ~tick_q`. Reset clears tick_q, so TickIn held high at reset release counts as an edge.
- States:
  - IDLE: waiting for the first edge. Entered on reset and on timeout.
  - MEASURE: counting.
- IDLE + edge -> MEASURE, `cnt <= 1`. No result is produced.
- MEASURE + edge -> `Period <= cnt`, `Code <= cnt[CNT_W-1:SHIFT]`, `Valid <= 1`, `cnt <= 1`. The state stays MEASURE.
- MEASURE without an edge: `cnt <= cnt + 1`, saturating at 2^CNT_W-1.
- MEASURE with `cnt == 2^CNT_W-1` and no edge -> IDLE, `Stalled <= 1`. Period, Code and Valid are left unchanged.
- Stalled clears on the next edge.
- Handshake:
  - Ack with Valid high clears Valid and Overrun in the next cycle.
  - Ack with Valid low has no effect.
- New result while Valid is high and Ack is low: the result overwrites Period/Code, Valid stays high, and `Overrun <= 1`.
- New result in the same cycle as Ack: the new result is loaded, Valid stays 1, and Overrun is cleared (not set). The new result wins.
- Arithmetic:
  - A result equals the number of cycles between edges: edges at cycles t and t+N give Period = N. The minimum is N = 2, since TickIn alternating each cycle gives an edge every 2 cycles.
  - Code truncates; no rounding.
  - A divider with speed = {code, 20'b10} has Period = code·2^20 + 2, so Code reproduces the original code exactly.
- Reset, also mid-measurement: `state = IDLE`, `cnt = 0`, `tick_q = 0`, `Period = 0`, `Code = 0`, `Valid = 0`, `Overrun = 0`, `Stalled = 0`. Any in-progress interval is discarded.

## Timing
- Latency: the result is registered in the edge cycle, so Period/Code/Valid are visible one cycle after the first cycle TickIn is sampled high.
- Stalled rises one cycle after the saturating cycle.
- There are no combinational paths from inputs to outputs; all outputs are registered.
- Back-to-back results are possible every 2 cycles.

## Structure
- Package `clk_delay_pkg` holds:
  - the constants CNT_W, SHIFT, CODE_W, shared with the clock-delay divider;
  - the state enum `meter_state_t` {IDLE, MEASURE}.
- Sub-module `rise_detect`: the one-register rising-edge detector with synchronous reset, reusable for other tick inputs.
- The top level contains the FSM, the saturating counter, and the output/handshake registers.

## Test plan
- Reset, then TickIn alternating 1/0 each cycle -> after the second edge, Period = 2, Code = 0, Valid = 1; the first edge produces no result.
- Edges 1048578 cycles apart (code 1 divider speed) -> Period = 1048578, Code = 1; Ack clears Valid next cycle.
- Two results without Ack -> Valid = 1, Overrun = 1, Period = the second interval. Then Ack -> both clear.
- Ack in the same cycle as a new result -> Valid = 1, Overrun = 0, new Period loaded.
- No edge for 2^28-1 cycles after one edge (CNT_W may be overridden to 8 for speed: 255 cycles) -> Stalled = 1, IDLE. The next edge clears Stalled and produces no result; the edge after that produces a result.
- Reset asserted mid-interval with Valid = 1 -> all outputs 0 next cycle. TickIn high at release is counted as an edge; the first result comes from the following edge.
